uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: serialiser states and frame constants.
package uart_pkg;

    localparam int CLKS_PER_BIT_19200 = 2604;
    localparam int FRAME_BITS         = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and full/empty flags derived from it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_50M,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_full   = (r_count == (ADDR_W + 1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];

    always_ff @(posedge clk_50M) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_19200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk_50M,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(FRAME_BITS - 3);

    txState_e                    r_state;
    txState_e                    w_nextState;
    logic [BAUD_W-1:0]           r_baud;
    logic [2:0]                  r_bitIdx;
    logic [7:0]                  r_shift;
    logic                        r_tx;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_bitDone;
    logic                        w_full;
    logic                        w_empty;
    logic [7:0]                  w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_data),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push     = in_valid && in_ready;
    assign in_ready   = !w_full;
    assign fifo_count = w_count;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign w_bitDone  = (r_baud == BAUD_LAST);

    // Popping happens on the same edge that enters START, so no idle gap separates queued frames.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = START;
                end
            end
            START: begin
                if (w_bitDone) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_bitDone && (r_bitIdx == LAST_BIT)) begin
                    w_nextState = STOP;
                end
            end
            STOP: begin
                if (w_bitDone) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = START;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Every state exit coincides with a bit boundary, so wrapping on bitDone also reloads on entry.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            if ((r_state == IDLE) || w_bitDone) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if ((r_state == DATA) && w_bitDone) begin
                r_bitIdx <= r_bitIdx + 1'b1;
            end

            if (w_pop) begin
                r_shift <= w_head;
            end else if ((r_state == DATA) && w_bitDone) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end

            case (r_state)
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
        end
    end

endmodule
